// File: rtl/adder_io_pkg.sv
// Shared definitions for the adder system's input conditioning logic.
// Holds the debounce defaults and the per-channel state type.
package adder_io_pkg;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
   localparam int CLK_HZ                  = 50_000_000;

   typedef enum logic [0:0] {
      STABLE  = 1'b0,
      CONFIRM = 1'b1
   } chan_state_e;

endpackage

// File: rtl/adder_debounce_chan.sv
// One input bit: a two-flop synchroniser followed by a persistence counter.
// A new level is accepted only after it holds for DEBOUNCE_CYCLES cycles.
module adder_debounce_chan
   import adder_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
)(
   input  logic clk,
   input  logic reset_n,
   input  logic raw_in,
   output logic level,
   output logic rise,
   output logic fall,
   output logic accept
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_r;
   logic             sync2_r;
   chan_state_e      state_r;
   chan_state_e      state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             accept_s;
   logic             level_r;
   logic             rise_r;
   logic             fall_r;

   // Bring the asynchronous input into the clk domain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= raw_in;
         sync2_r <= sync1_r;
      end
   end

   // Next state and count; any return to the current level abandons the candidate.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      accept_s    = 1'b0;
      case (state_r)
         STABLE: begin
            if (sync2_r != level_r) begin
               state_nxt_s = CONFIRM;
               cnt_nxt_s   = CNT_ONE;
            end else begin
               cnt_nxt_s   = CNT_ZERO;
            end
         end
         CONFIRM: begin
            if (sync2_r == level_r) begin
               state_nxt_s = STABLE;
               cnt_nxt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = STABLE;
               cnt_nxt_s   = CNT_ZERO;
               accept_s    = 1'b1;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_nxt_s = STABLE;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // State, counter, debounced level and edge strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= STABLE;
         cnt_r   <= CNT_ZERO;
         level_r <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         if (accept_s) begin
            level_r <= sync2_r;
         end else begin
            level_r <= level_r;
         end
         rise_r  <= accept_s & sync2_r;
         fall_r  <= accept_s & ~sync2_r;
      end
   end

   assign level  = level_r;
   assign rise   = rise_r;
   assign fall   = fall_r;
   assign accept = accept_s;

endmodule

// File: rtl/adder_input_debounce.sv
// Debounces the raw switch/key levels feeding the adder PIO in_port and
// produces registered per-bit rise/fall strobes plus a combined change strobe.
module adder_input_debounce
   import adder_io_pkg::*;
#(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             change
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

   logic [WIDTH-1:0] accept_s;
   logic             change_r;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_chan
         adder_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .raw_in  (raw_in[i]),
            .level   (in_port[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .accept  (accept_s[i])
         );
      end
   endgenerate

   // Change strobe is taken from the same acceptance that loads rise/fall.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         change_r <= 1'b0;
      end else begin
         change_r <= |accept_s;
      end
   end

   assign change = change_r;

endmodule

// File: doc/adder_input_debounce.md
Name: adder_input_debounce

Overview:
Conditioning stage directly upstream of the 2-bit Avalon input PIO in the adder Nios system. Takes raw, asynchronous DE10 slide-switch/key levels. Synchronises and debounces each bit independently, then drives the clean level into the PIO's in_port. Also emits single-cycle rise/fall/change strobes for optional interrupt or edge-capture logic.

Parameters:
WIDTH, 2, number of independent input bits.
DEBOUNCE_CYCLES, 500000, consecutive cycles a new synchronised level must persist before acceptance (10 ms at 50 MHz); legal range >= 2.
CNT_W, $clog2(DEBOUNCE_CYCLES), counter width; derived, not overridden.

Ports:
clk  input  1  system clock, single clock domain.
reset_n  input  1  asynchronous, active-low reset.
raw_in  input  WIDTH  raw switch/key levels, asynchronous to clk.
in_port  output  WIDTH  debounced level; connects to the PIO in_port.
rise  output  WIDTH  one-cycle pulse per bit when in_port bit goes 0->1.
fall  output  WIDTH  one-cycle pulse per bit when in_port bit goes 1->0.
change  output  1  OR-reduction of rise|fall, registered in the same cycle as them.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on reset_n. All flops clear on reset_n low, no clock needed.
- Reset values: sync stages 0, in_port 0, rise 0, fall 0, change 0, all counters 0, all channels in STABLE.
- Per bit, 2-flop synchroniser: s1 <= raw_in[i], s2 <= s1. Only s2 feeds the logic; raw_in is never used combinationally.
- Per-bit FSM with states STABLE and CONFIRM. d = current in_port bit.
  - STABLE, s2 == d: hold, cnt = 0.
  - STABLE, s2 != d: go to CONFIRM, cnt <= 1.
  - CONFIRM, s2 == d (glitch ended): back to STABLE, cnt <= 0, no output change, no pulse.
  - CONFIRM, s2 != d, cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - CONFIRM, s2 != d, cnt == DEBOUNCE_CYCLES-1: d <= s2, rise/fall pulse as appropriate, cnt <= 0, go to STABLE.
- Latency: a clean raw transition sampled at edge E0 appears on in_port after edge E0+DEBOUNCE_CYCLES+1. Pulses are high for exactly the one cycle following that edge.
- rise, fall, change are registered outputs. rise[i] and fall[i] are never both high.
- Channels are fully independent. Simultaneous acceptance on several bits gives multiple rise/fall bits set in the same cycle and a single change pulse.
- Counter saturates by construction (cleared on acceptance). No wrap-around is possible.
- Reset asserted mid-CONFIRM: count is discarded and in_port returns to 0. After release, a raw level of 1 is re-debounced from scratch, taking full latency, and produces a rise pulse.
- Bounce shorter than DEBOUNCE_CYCLES synchronised cycles never reaches in_port.

Decomposition:
- Shared package adder_io_pkg: DEBOUNCE_CYCLES_DEFAULT (500000), CLK_HZ (50_000_000), channel state enum {STABLE, CONFIRM}.
- One sub-module adder_debounce_chan: single-bit synchroniser, counter and FSM, with outputs level/rise/fall.
- Top level instantiates WIDTH channels via generate and ORs the strobes into change.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset: hold reset_n=0 with raw_in=2'b11, then release -> in_port=0 and strobes 0 during reset. in_port=2'b11 after 5 edges, with rise=2'b11 and change=1 for one cycle.
- Clean step: raw_in[0] 0->1 sampled at edge E0 -> in_port[0]=1 after E0+5, rise=2'b01 for one cycle, fall=0.
- Bounce rejection: raw_in[1] pulses high for 2 cycles, then low -> in_port stays 2'b00, no strobes, channel counter returns to 0.
- Bounce then settle: raw_in[0] toggles 1,0,1,0,1 per cycle then stays 1 -> single rise pulse, 5 edges after the final 0->1 sample.
- Simultaneous opposite edges: in_port=2'b01, raw_in -> 2'b10 at once -> after 5 edges in_port=2'b10, rise=2'b10, fall=2'b01, change=1 for one cycle.
- Reset mid-confirm: raw_in[0] rises, reset_n pulsed low 2 cycles later -> in_port stays 0. After release, rise[0] occurs 5 edges after the first post-reset sample.
